mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, meaning address width.
REQ-002 SHALL have parameter DW, default 16, meaning data width.
REQ-003 SHALL have parameter BURST_MAX, default 4, meaning max consecutive grants to one owner while the other waits; legal range 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports m0_req/m1_req  input  1 each  access request (m0 = CPU, m1 = DMA/loader).
REQ-007 SHALL have ports m0_we/m1_we  input  1 each  write (1) / read (0) qualifier.
REQ-008 SHALL have ports m0_addr/m1_addr  input  AW each  access address.
REQ-009 SHALL have ports m0_wdata/m1_wdata  input  DW each  write data.
REQ-010 SHALL have ports m0_gnt/m1_gnt  output  1 each  access performed this cycle.
REQ-011 SHALL have ports m0_rdata/m1_rdata  output  DW each  read data.
REQ-012 SHALL have ports m0_rvalid/m1_rvalid  output  1 each  rdata valid.
REQ-013 SHALL have port mem_addr  output  AW  memory address.
REQ-014 SHALL have port mem_wdata  output  DW  memory write data.
REQ-015 SHALL have port mem_we  output  1  memory write enable.
REQ-016 SHALL have port mem_rdata  input  DW  synchronous memory read data, valid one cycle after address.

Function
REQ-017 SHALL hold a registered owner state: IDLE, OWN0, OWN1.
REQ-018 SHALL drive gnt combinationally in the same cycle as req: IDLE grants the requester (tie rule REQ-024); OWNn grants mn while mn_req=1.
REQ-019 SHALL set at most one gnt per cycle; gnt never asserted without the matching req.
REQ-020 SHALL drive mem_addr/mem_wdata from the granted master, mem_we = gnt & we; with no grant mem_we=0 and mem_addr/mem_wdata hold their last values.
REQ-021 SHALL transition: IDLE->OWNn on grant to mn; OWNn->IDLE when mn_req drops and the other is idle; OWNn->OWNm (m≠n) with a same-cycle grant to mm when mn_req drops and mm_req=1.
REQ-022 SHALL count consecutive grants to the owner; once the count reaches BURST_MAX and the other master requests, the next cycle SHALL grant the other master and reset the count to 1.
REQ-023 SHALL saturate the count at BURST_MAX while the other master is idle (the owner keeps the bus indefinitely).
REQ-024 SHALL resolve IDLE ties (both req) per REQ-029/REQ-030.
REQ-025 SHALL assert mn_rvalid for exactly one cycle, one cycle after a granted read by mn, with mn_rdata = mem_rdata; otherwise mn_rdata holds its last value.
REQ-026 SHALL support back-to-back reads with one rvalid per grant; a write produces no rvalid.

Reset
REQ-027 SHALL on rst=1 set: state IDLE, burst count 0, last-winner = m1, m0_rvalid/m1_rvalid=0, mem_we=0, gnt=0, mem_addr/mem_wdata/mn_rdata = 0.
REQ-028 SHALL discard any read in flight when rst asserts mid-access (no rvalid after reset); requests seen in the cycle rst deasserts are arbitrated normally.

Configuration
REQ-029 With MEM_ARB_RR_EN defined, IDLE ties SHALL go to the master that did not win the previous arbitration (round robin; first tie after reset goes to m0).
REQ-030 Without MEM_ARB_RR_EN, IDLE ties SHALL always go to m0 (fixed priority); the burst limit (REQ-022) applies in both builds.

Structure
REQ-031 SHALL take AW/DW defaults and the owner-state enum (IDLE/OWN0/OWN1) from shared package toycpu_pkg.
REQ-032 SHALL implement burst counting in sub-module mem_arb_burst_cnt (inputs: grant, same-owner, other-req; output: limit-reached).

Verification
REQ-033 Reset: rst=1 for 2 cycles while m0_req=1 -> no gnt, mem_we=0, rvalid=0; first cycle after release m0_gnt=1.
REQ-034 Single read: m0 read addr 0x0003, mem_rdata=0x1234 -> m0_gnt same cycle, m0_rvalid=1 with rdata=0x1234 next cycle only.
REQ-035 Tie: both req from IDLE -> fixed build m0 wins both times; MEM_ARB_RR_EN build m0 then m1 on successive ties.
REQ-036 Burst: m0 holds req for 10 cycles, m1 req from cycle 1 -> m0 granted 4 cycles, then m1 granted, mem_addr switches to m1_addr.
REQ-037 Write: m1 writes 0xB520 to 0x0080 -> mem_we=1 one cycle, mem_wdata=0xB520, mem_addr=0x0080, no rvalid.
REQ-038 Reset mid-read: rst asserted the cycle after a granted m1 read -> m1_rvalid stays 0.

Source files
------------

// File: rtl/toycpu_pkg.sv
// Shared definitions for the toy CPU memory subsystem: default bus widths,
// the arbiter owner-state encoding and the burst-count helper.
package toycpu_pkg;

  localparam int TOYCPU_AW   = 16;
  localparam int TOYCPU_DW   = 16;
  localparam int BURST_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  function automatic logic [BURST_CNT_W-1:0] satInc(
    input logic [BURST_CNT_W-1:0] cnt,
    input logic [BURST_CNT_W-1:0] max
  );
    return (cnt >= max) ? cnt : cnt + BURST_CNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_arb_burst_cnt.sv
// Counts consecutive grants to the current bus owner and flags when the owner
// has used up its burst while the other master is waiting.
module mem_arb_burst_cnt
  import toycpu_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic grant_i,
  input  logic sameOwner_i,
  input  logic otherReq_i,
  output logic limitReached_o
);

  localparam logic [BURST_CNT_W-1:0] MAX_CNT = BURST_CNT_W'(BURST_MAX);

  logic [BURST_CNT_W-1:0] count_q, count_d;

  // A grant to a new owner restarts at 1; the count saturates so a lone owner keeps the bus.
  always_comb begin
    count_d = '0;
    if (grant_i) begin
      count_d = sameOwner_i ? satInc(count_q, MAX_CNT) : BURST_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign limitReached_o = (count_q == MAX_CNT) && otherReq_i;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port synchronous memory (m0 = CPU, m1 = DMA).
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise m0 wins ties.
module mem_arbiter
  import toycpu_pkg::*;
#(
  parameter int AW        = TOYCPU_AW,
  parameter int DW        = TOYCPU_DW,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  owner_e        state_q, state_d;
  logic          gnt0, gnt1, anyGnt;
  logic          tie, tieToM1, sameOwner, otherReq, limitReached;
  logic [AW-1:0] grantAddr, memAddr_q;
  logic [DW-1:0] grantWdata, memWdata_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          rdPend0_q, rdPend1_q;

  assign tie = (state_q == IDLE) && m0_req && m1_req;

`ifdef MEM_ARB_RR_EN
  // Remembers only tie outcomes, so the first tie after reset goes to m0.
  logic lastWinner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lastWinner_q <= 1'b1;
    end else if (tie) begin
      lastWinner_q <= gnt1;
    end
  end

  assign tieToM1 = ~lastWinner_q;
`else
  assign tieToM1 = 1'b0;
`endif

  assign otherReq  = ((state_q == OWN0) && m1_req) || ((state_q == OWN1) && m0_req);
  assign sameOwner = ((state_q == OWN0) && gnt0) || ((state_q == OWN1) && gnt1);
  assign anyGnt    = gnt0 | gnt1;

  mem_arb_burst_cnt #(
    .BURST_MAX(BURST_MAX)
  ) u_burstCnt (
    .clk_i         (clk),
    .rst_i         (rst),
    .grant_i       (anyGnt),
    .sameOwner_i   (sameOwner),
    .otherReq_i    (otherReq),
    .limitReached_o(limitReached)
  );

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = IDLE;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (tie) begin
            gnt0 = ~tieToM1;
            gnt1 = tieToM1;
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
        OWN0: begin
          if (m0_req && !limitReached) gnt0 = 1'b1;
          else                         gnt1 = m1_req;
        end
        OWN1: begin
          if (m1_req && !limitReached) gnt1 = 1'b1;
          else                         gnt0 = m0_req;
        end
        default: ;
      endcase
    end
    if (gnt0)      state_d = OWN0;
    else if (gnt1) state_d = OWN1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign grantAddr  = gnt1 ? m1_addr  : m0_addr;
  assign grantWdata = gnt1 ? m1_wdata : m0_wdata;
  assign mem_addr   = anyGnt ? grantAddr  : memAddr_q;
  assign mem_wdata  = anyGnt ? grantWdata : memWdata_q;
  assign mem_we     = (gnt0 & m0_we) | (gnt1 & m1_we);
  assign m0_gnt     = gnt0;
  assign m1_gnt     = gnt1;

  // Read data returns one cycle after the grant; rst masks any read still in flight.
  assign m0_rvalid = rdPend0_q & ~rst;
  assign m1_rvalid = rdPend1_q & ~rst;
  assign m0_rdata  = m0_rvalid ? mem_rdata : rdata0_q;
  assign m1_rdata  = m1_rvalid ? mem_rdata : rdata1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      memAddr_q  <= '0;
      memWdata_q <= '0;
      rdPend0_q  <= 1'b0;
      rdPend1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      if (anyGnt) begin
        memAddr_q  <= grantAddr;
        memWdata_q <= grantWdata;
      end
      rdPend0_q <= gnt0 & ~m0_we;
      rdPend1_q <= gnt1 & ~m1_we;
      if (m0_rvalid) rdata0_q <= mem_rdata;
      if (m1_rvalid) rdata1_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants and read
// returns, a negedge monitor pops and compares them. Honours MEM_ARB_RR_EN.
module tb_mem_arbiter;

  typedef struct {
    int          cyc;
    logic        master;
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
  } gntExp_t;

  typedef struct {
    int          cyc;
    logic        master;
    logic [15:0] data;
  } rdExp_t;

  logic        clk, rst;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [15:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
  logic [15:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [15:0] memArr [256];
  logic        memInit;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  gntExp_t     gntQ [$];
  rdExp_t      rdQ  [$];
  logic [9:0]  burstOwner = 10'b0011110000;

`ifdef MEM_ARB_RR_EN
  localparam logic SECOND_TIE = 1'b1;
`else
  localparam logic SECOND_TIE = 1'b0;
`endif

  mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (m0_req),
    .m1_req   (m1_req),
    .m0_we    (m0_we),
    .m1_we    (m1_we),
    .m0_addr  (m0_addr),
    .m1_addr  (m1_addr),
    .m0_wdata (m0_wdata),
    .m1_wdata (m1_wdata),
    .m0_gnt   (m0_gnt),
    .m1_gnt   (m1_gnt),
    .m0_rdata (m0_rdata),
    .m1_rdata (m1_rdata),
    .m0_rvalid(m0_rvalid),
    .m1_rvalid(m1_rvalid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory model: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 256; i++) memArr[i] <= 16'hA000 + 16'(i);
      memArr[3] <= 16'h1234;
    end else begin
      if (mem_we) memArr[mem_addr[7:0]] <= mem_wdata;
      if ((m0_gnt || m1_gnt) && !mem_we) mem_rdata <= memArr[mem_addr[7:0]];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rstV,
                               input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                               input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1);
    rst = rstV;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic expectGnt(input logic m, input logic [15:0] a, input logic w, input logic [15:0] d);
    gntExp_t e;
    e.cyc = cyc; e.master = m; e.addr = a; e.we = w; e.wdata = d;
    gntQ.push_back(e);
  endtask

  task automatic expectRd(input logic m, input logic [15:0] d);
    rdExp_t e;
    e.cyc = cyc + 1; e.master = m; e.data = d;
    rdQ.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Monitor: every grant and every rvalid must match the head of its queue in this exact cycle.
  always @(negedge clk) begin
    gntExp_t g;
    rdExp_t  r;
    checkOutput("gnt_onehot", {31'b0, m0_gnt & m1_gnt}, 32'd0);
    if (m0_gnt || m1_gnt) begin
      if (gntQ.size() == 0 || gntQ[0].cyc != cyc) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_gnt cyc=%0d actual m0=%b m1=%b required none", cyc, m0_gnt, m1_gnt);
      end else begin
        g = gntQ.pop_front();
        checkOutput("gnt_master", {31'b0, m1_gnt}, {31'b0, g.master});
        checkOutput("mem_addr",   {16'b0, mem_addr},  {16'b0, g.addr});
        checkOutput("mem_we",     {31'b0, mem_we},    {31'b0, g.we});
        checkOutput("mem_wdata",  {16'b0, mem_wdata}, {16'b0, g.wdata});
      end
    end
    while (gntQ.size() != 0 && gntQ[0].cyc <= cyc) begin
      g = gntQ.pop_front();
      checks++; errors++;
      $display("[TB] FAIL missing_gnt cyc=%0d actual none required m%0d", cyc, g.master);
    end
    checkOutput("rvalid_onehot", {31'b0, m0_rvalid & m1_rvalid}, 32'd0);
    if (m0_rvalid || m1_rvalid) begin
      if (rdQ.size() == 0 || rdQ[0].cyc != cyc) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_rvalid cyc=%0d actual m0=%b m1=%b required none", cyc, m0_rvalid, m1_rvalid);
      end else begin
        r = rdQ.pop_front();
        checkOutput("rvalid_master", {31'b0, m1_rvalid}, {31'b0, r.master});
        checkOutput("rdata", {16'b0, (m1_rvalid ? m1_rdata : m0_rdata)}, {16'b0, r.data});
      end
    end
    while (rdQ.size() != 0 && rdQ[0].cyc <= cyc) begin
      r = rdQ.pop_front();
      checks++; errors++;
      $display("[TB] FAIL missing_rvalid cyc=%0d actual none required m%0d", cyc, r.master);
    end
  end

  initial begin
    // Reset held two cycles with m0 requesting; m0 must win the release cycle.
    memInit = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    nextCycle();
    memInit = 1'b0;
    checkOutput("rst_m0_gnt",    {31'b0, m0_gnt},    32'd0);
    checkOutput("rst_mem_we",    {31'b0, mem_we},    32'd0);
    checkOutput("rst_m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
    checkOutput("rst_mem_addr",  {16'b0, mem_addr},  32'd0);
    checkOutput("rst_m0_rdata",  {16'b0, m0_rdata},  32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    expectGnt(1'b0, 16'h0010, 1'b0, 16'h0);
    expectRd(1'b0, 16'hA010);
    #1 checkOutput("release_m0_gnt", {31'b0, m0_gnt}, 32'd1);
    nextCycle();
    idle();
    #1 checkOutput("hold_mem_addr", {16'b0, mem_addr}, 32'h0010);
    checkOutput("idle_mem_we", {31'b0, mem_we}, 32'd0);
    nextCycle();
    idle();
    #1 checkOutput("hold_m0_rdata", {16'b0, m0_rdata}, 32'hA010);
    nextCycle();

    // Single read of address 3.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    expectGnt(1'b0, 16'h0003, 1'b0, 16'h0);
    expectRd(1'b0, 16'h1234);
    nextCycle();
    idle(); nextCycle();
    idle(); nextCycle();

    // Two ties from IDLE, separated by an idle cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0, 1'b1, 1'b0, 16'h0005, 16'h0);
    expectGnt(1'b0, 16'h0004, 1'b0, 16'h0);
    expectRd(1'b0, 16'hA004);
    nextCycle();
    idle(); nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0, 1'b1, 1'b0, 16'h0005, 16'h0);
    expectGnt(SECOND_TIE, SECOND_TIE ? 16'h0005 : 16'h0004, 1'b0, 16'h0);
    expectRd(SECOND_TIE, SECOND_TIE ? 16'hA005 : 16'hA004);
    nextCycle();
    idle(); nextCycle();

    // Burst limit: m0 reads for 10 cycles, m1 competes from cycle 1.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, (i >= 1), 1'b0, 16'h0030, 16'h0);
      expectGnt(burstOwner[i], burstOwner[i] ? 16'h0030 : 16'h0020, 1'b0, 16'h0);
      expectRd(burstOwner[i], burstOwner[i] ? 16'hA030 : 16'hA020);
      nextCycle();
    end
    idle(); nextCycle();

    // Saturated owner: m0 writes alone for 6 cycles, m1 then takes over immediately.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0040 + 16'(i), 16'h5A00 + 16'(i),
                    (i == 6), 1'b0, 16'h0041, 16'h0);
      if (i < 6) begin
        expectGnt(1'b0, 16'h0040 + 16'(i), 1'b1, 16'h5A00 + 16'(i));
      end else begin
        expectGnt(1'b1, 16'h0041, 1'b0, 16'h0);
        expectRd(1'b1, 16'h5A01);
      end
      nextCycle();
    end
    idle(); nextCycle();

    // m1 write, idle with held address/data, then m0 reads the written word back.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0080, 16'hB520);
    expectGnt(1'b1, 16'h0080, 1'b1, 16'hB520);
    nextCycle();
    idle();
    #1 checkOutput("wr_no_rvalid", {31'b0, m1_rvalid}, 32'd0);
    checkOutput("wr_mem_we_off", {31'b0, mem_we},    32'd0);
    checkOutput("hold_wdata",    {16'b0, mem_wdata}, 32'hB520);
    checkOutput("hold_addr_wr",  {16'b0, mem_addr},  32'h0080);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0080, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    expectGnt(1'b0, 16'h0080, 1'b0, 16'h0);
    expectRd(1'b0, 16'hB520);
    nextCycle();
    idle(); nextCycle();

    // Ownership handoff: m1 drops while m0 requests.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0030, 16'h0);
    expectGnt(1'b1, 16'h0030, 1'b0, 16'h0);
    expectRd(1'b1, 16'hA030);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    expectGnt(1'b0, 16'h0003, 1'b0, 16'h0);
    expectRd(1'b0, 16'h1234);
    nextCycle();
    idle(); nextCycle();

    // Reset the cycle after a granted m1 read: its data must never be reported.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0005, 16'h0);
    expectGnt(1'b1, 16'h0005, 1'b0, 16'h0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    #1 checkOutput("midrst_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    checkOutput("midrst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    nextCycle();
    idle();
    #1 checkOutput("postrst_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
    checkOutput("postrst_m1_rdata", {16'b0, m1_rdata}, 32'd0);
    nextCycle();
    nextCycle();
    nextCycle();

    checkOutput("gnt_queue_empty", 32'(gntQ.size()), 32'd0);
    checkOutput("rd_queue_empty",  32'(rdQ.size()),  32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
